out_port_fifo: RTL and testbench

OUT_PORT_FIFO -- requirements
Module: out_port_fifo

---
 rtl/out_port_pkg.sv | 14 +
 rtl/out_chan_fifo.sv | 52 +++++
 rtl/out_port_fifo.sv | 48 ++++
 tb/tb_out_port_fifo.sv | 114 +++++++++++
 4 files changed

// File: rtl/out_port_pkg.sv
// out_port_pkg: shared defaults and width helpers for the output port FIFO
package out_port_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 4;
  localparam int NUM_CH_DEF = 2;
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction
  localparam int PTR_W = ptr_w(DEPTH_DEF);
  localparam int LVL_W = lvl_w(DEPTH_DEF);
endpackage

// File: rtl/out_chan_fifo.sv
// out_chan_fifo: one circular channel FIFO with occupancy count and drop detect
module out_chan_fifo
  import out_port_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push_i,
  input  logic [DATA_W-1:0]         data_i,
  input  logic                      ready_i,
  output logic [DATA_W-1:0]         data_o,
  output logic                      valid_o,
  output logic                      full_o,
  output logic [lvl_w(DEPTH)-1:0]   level_o,
  output logic                      drop_o
);
  localparam int PW = ptr_w(DEPTH);
  localparam int LW = lvl_w(DEPTH);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] level_q, level_d;
  logic pop, push_ok;
  assign valid_o = level_q != '0;
  assign full_o  = level_q == LW'(DEPTH);
  assign pop     = valid_o & ready_i;
  // a full channel still accepts when the head leaves on the same edge
  assign push_ok = push_i & (~full_o | pop);
  assign drop_o  = push_i & full_o & ~pop;
  assign data_o  = valid_o ? mem_q[rd_q] : '0;
  assign level_o = level_q;
  always_comb begin
    wr_d    = push_ok ? wr_q + PW'(1) : wr_q;
    rd_d    = pop ? rd_q + PW'(1) : rd_q;
    level_d = level_q + LW'(push_ok) - LW'(pop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/out_port_fifo.sv
// out_port_fifo: multi-channel output port; decodes writes, tracks overflow, packs channel outputs
module out_port_fifo
  import out_port_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int NUM_CH = NUM_CH_DEF,
  localparam int CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int LW    = lvl_w(DEPTH)
) (
  input  logic                     Clock,
  input  logic                     Clear,
  input  logic [DATA_W-1:0]        BusMuxOut,
  input  logic                     OutPort,
  input  logic [CW-1:0]            ChSel,
  input  logic                     Broadcast,
  input  logic                     OvfClr,
  output logic [NUM_CH*DATA_W-1:0] OutData,
  output logic [NUM_CH-1:0]        OutValid,
  input  logic [NUM_CH-1:0]        OutReady,
  output logic [NUM_CH-1:0]        Full,
  output logic [NUM_CH-1:0]        Overflow,
  output logic [NUM_CH*LW-1:0]     Level
);
  logic [NUM_CH-1:0] we, drop, ovf_q, ovf_d;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    // out-of-range ChSel matches no channel, so it is silently ignored
    assign we[c] = OutPort & (Broadcast | (ChSel == CW'(c)));
    out_chan_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk    (Clock),
      .rst    (Clear),
      .push_i (we[c]),
      .data_i (BusMuxOut),
      .ready_i(OutReady[c]),
      .data_o (OutData[c*DATA_W +: DATA_W]),
      .valid_o(OutValid[c]),
      .full_o (Full[c]),
      .level_o(Level[c*LW +: LW]),
      .drop_o (drop[c])
    );
  end
  assign ovf_d    = (OvfClr ? '0 : ovf_q) | drop;
  assign Overflow = ovf_q;
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) ovf_q <= '0;
    else       ovf_q <= ovf_d;
  end
endmodule

// File: tb/tb_out_port_fifo.sv
// tb_out_port_fifo: directed scenarios plus random traffic against a queue-based model
module tb_out_port_fifo;
  localparam int DW = 32, DEPTH = 4, NCH = 3, CW = 2, LW = 3;
  logic Clock = 0, Clear = 1, OutPort = 0, Broadcast = 0, OvfClr = 0;
  logic [DW-1:0] BusMuxOut = '0;
  logic [CW-1:0] ChSel = '0;
  logic [NCH-1:0] OutReady = '0, OutValid, Full, Overflow;
  logic [NCH*DW-1:0] OutData;
  logic [NCH*LW-1:0] Level;
  int n_tests = 0, n_fail = 0;
  logic [DW-1:0] mq [NCH][$];
  logic [NCH-1:0] movf = '0;
  out_port_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .NUM_CH(NCH)) dut (
    .Clock(Clock), .Clear(Clear), .BusMuxOut(BusMuxOut), .OutPort(OutPort),
    .ChSel(ChSel), .Broadcast(Broadcast), .OvfClr(OvfClr), .OutData(OutData),
    .OutValid(OutValid), .OutReady(OutReady), .Full(Full), .Overflow(Overflow),
    .Level(Level)
  );
  always #5 Clock = ~Clock;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_all(input string tag);
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("%s valid%0d", tag, c), 64'(OutValid[c]), 64'(mq[c].size() != 0));
      chk($sformatf("%s full%0d", tag, c), 64'(Full[c]), 64'(mq[c].size() == DEPTH));
      chk($sformatf("%s ovf%0d", tag, c), 64'(Overflow[c]), 64'(movf[c]));
      chk($sformatf("%s level%0d", tag, c), 64'(Level[c*LW +: LW]), 64'(mq[c].size()));
      chk($sformatf("%s data%0d", tag, c), 64'(OutData[c*DW +: DW]),
          64'(mq[c].size() != 0 ? mq[c][0] : '0));
    end
  endtask
  // model: one clock edge of the whole port given the currently driven inputs
  task automatic model_edge();
    for (int c = 0; c < NCH; c++) begin
      bit pop = mq[c].size() != 0 && OutReady[c];
      bit push = OutPort && (Broadcast || int'(ChSel) == c);
      if (OvfClr) movf[c] = 0;
      if (push && mq[c].size() == DEPTH && !pop) movf[c] = 1;
      else begin
        if (pop) void'(mq[c].pop_front());
        if (push) mq[c].push_back(BusMuxOut);
      end
    end
  endtask
  task automatic step(input string tag, input bit port, input bit bc, input int sel,
                      input logic [DW-1:0] d, input logic [NCH-1:0] rdy, input bit clr);
    OutPort = port; Broadcast = bc; ChSel = CW'(sel); BusMuxOut = d; OutReady = rdy; OvfClr = clr;
    model_edge();
    @(negedge Clock);
    check_all(tag);
  endtask
  task automatic model_reset();
    for (int c = 0; c < NCH; c++) mq[c].delete();
    movf = '0;
  endtask
  initial begin
    #3 check_all("reset");
    @(negedge Clock) Clear = 0;
    step("single_push", 1, 0, 0, 32'hA5, '0, 0);
    chk("single_data", 64'(OutData[DW-1:0]), 64'hA5);
    chk("single_lvl", 64'(Level[LW-1:0]), 64'd1);
    step("single_pop", 0, 0, 0, 0, 3'b001, 0);
    chk("single_empty", 64'(OutValid), 64'd0);
    for (int i = 1; i <= 5; i++) step("fill1", 1, 0, 1, 32'(i * 'h11), '0, 0);
    chk("fill_full1", 64'(Full[1]), 64'd1);
    chk("fill_ovf1", 64'(Overflow[1]), 64'd1);
    for (int i = 1; i <= 4; i++) begin
      chk("drain1_word", 64'(OutData[DW +: DW]), 64'(i * 'h11));
      step("drain1", 0, 0, 0, 0, 3'b010, 0);
    end
    step("ovfclr", 0, 0, 0, 0, '0, 1);
    for (int i = 1; i <= 4; i++) step("fill0", 1, 0, 0, 32'(i), '0, 0);
    step("full_pushpop", 1, 0, 0, 32'h5, 3'b001, 0);
    chk("fpp_lvl", 64'(Level[LW-1:0]), 64'd4);
    chk("fpp_ovf", 64'(Overflow[0]), 64'd0);
    for (int i = 2; i <= 5; i++) begin
      chk("fpp_word", 64'(OutData[DW-1:0]), 64'(i));
      step("fpp_drain", 0, 0, 0, 0, 3'b001, 0);
    end
    for (int i = 0; i < 4; i++) step("bc_fill1", 1, 0, 1, 32'(i), '0, 0);
    step("bcast", 1, 1, 0, 32'hDEAD_BEEF, '0, 0);
    chk("bc_data0", 64'(OutData[DW-1:0]), 64'hDEAD_BEEF);
    chk("bc_ovf", 64'(Overflow), 64'b010);
    step("bc_clr_win", 1, 1, 0, 32'h1234, '0, 1);
    chk("clr_win_ovf", 64'(Overflow), 64'b010);
    for (int i = 0; i < 5; i++) step("bc_drain", 0, 0, 0, 0, '1, 1);
    step("bad_sel", 1, 0, 3, 32'hBAD, '0, 0);
    chk("bad_sel_lvl", 64'(Level), 64'd0);
    for (int i = 0; i < 3; i++) step("pre_rst", 1, 0, 0, 32'h70 + 32'(i), '0, 0);
    #2 Clear = 1;
    model_reset();
    #1 check_all("mid_rst");
    chk("mid_rst_data", 64'(OutData[DW-1:0]), 64'd0);
    #1 Clear = 0;
    step("post_rst", 1, 0, 0, 32'h99, '0, 0);
    step("post_rst_pop", 0, 0, 0, 0, 3'b001, 0);
    for (int i = 0; i < 10; i++) begin
      step("wrap", 1, 0, 0, 32'h100 + 32'(i), 3'b001, 0);
      chk("wrap_word", 64'(OutData[DW-1:0]), 64'h100 + 64'(i));
    end
    step("wrap_end", 0, 0, 0, 0, 3'b001, 0);
    chk("wrap_ovf", 64'(Overflow), 64'd0);
    for (int i = 0; i < 2000; i++)
      step("rand", $urandom_range(0, 2) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 3),
           $urandom, NCH'($urandom), $urandom_range(0, 7) == 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
